// File: rtl/simd_pkg.sv
// rtl/simd_pkg.sv - shared opcodes, instruction width and FSM state type for the SIMD issue arbiter
package simd_pkg;

  localparam int INSTR_W = 16;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Anything that is neither ADD nor MUL is reserved and never reaches the core.
  function automatic logic is_reserved(input logic [1:0] op);
    return (op != OP_ADD) && (op != OP_MUL);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant, search starts just after ptr
module rr_arbiter
  import simd_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx
);

  logic [PTR_W:0] cand;
  logic           found;

  // Walk ptr+1, ptr+2, ... (mod NUM_REQ) and take the first active request.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NUM_REQ)) begin
        cand = cand - (PTR_W+1)'(NUM_REQ);
      end
      if (!found && req[cand[PTR_W-1:0]]) begin
        found                    = 1'b1;
        grant[cand[PTR_W-1:0]]   = 1'b1;
        grant_idx                = cand[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/simd_issue_arbiter.sv
// rtl/simd_issue_arbiter.sv - round-robin issue of vector ops to a shared SIMD core; SIMD_ARB_STATS_EN adds grant_cnt
module simd_issue_arbiter
  import simd_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int LANE_W   = 32,
  parameter int LANES    = 4,
  parameter int CORE_LAT = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*INSTR_W-1:0]        req_instr,
  input  logic [NUM_REQ*LANES*LANE_W-1:0]   req_a,
  input  logic [NUM_REQ*LANES*LANE_W-1:0]   req_b,
  output logic [INSTR_W-1:0]                core_instruction,
  output logic [LANES*LANE_W-1:0]           core_src_a,
  output logic [LANES*LANE_W-1:0]           core_src_b,
  input  logic [LANES*LANE_W-1:0]           core_result,
  output logic [NUM_REQ-1:0]                rsp_valid,
  input  logic                              rsp_ready,
  output logic [LANES*LANE_W-1:0]           rsp_data,
  output logic                              rsp_err
`ifdef SIMD_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]             grant_cnt
`endif
);

  localparam int VEC_W = LANES * LANE_W;
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = 3;

  state_t               state;
  state_t               state_nxt;
  logic [PTR_W-1:0]     ptr;
  logic [NUM_REQ-1:0]   grant;
  logic [PTR_W-1:0]     grant_idx;
  logic [NUM_REQ-1:0]   owner;
  logic [CNT_W-1:0]     cnt;
  logic                 transfer;
  logic                 reserved_sel;
  logic [INSTR_W-1:0]   sel_instr;
  logic [VEC_W-1:0]     sel_a;
  logic [VEC_W-1:0]     sel_b;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Steer the granted requester's instruction and operands toward the holding registers.
  always_comb begin
    sel_instr = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_instr = req_instr[i*INSTR_W +: INSTR_W];
        sel_a     = req_a[i*VEC_W +: VEC_W];
        sel_b     = req_b[i*VEC_W +: VEC_W];
      end
    end
  end

  // Reset also gates the handshake so nothing is offered while reset is held low.
  assign transfer     = reset && (state == IDLE) && (|(req_valid & grant));
  assign reserved_sel = is_reserved(sel_instr[15:14]);
  assign rsp_valid    = (state == RESP) ? owner : '0;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and request-side handshake.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        req_ready = reset ? grant : '0;
        if (transfer) begin
          state_nxt = reserved_sel ? RESP : EXEC;
        end
      end
      EXEC: begin
        if (cnt <= CNT_W'(1)) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Holding registers, latency counter, owner tracking and response capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr              <= PTR_W'(NUM_REQ - 1);
      owner            <= '0;
      cnt              <= '0;
      core_instruction <= '0;
      core_src_a       <= '0;
      core_src_b       <= '0;
      rsp_data         <= '0;
      rsp_err          <= 1'b0;
    end else begin
      if (transfer) begin
        ptr   <= grant_idx;
        owner <= grant;
        if (reserved_sel) begin
          // Reserved ops bypass the core, so the core keeps seeing the last real op.
          rsp_data <= '0;
          rsp_err  <= 1'b1;
        end else begin
          core_instruction <= sel_instr;
          core_src_a       <= sel_a;
          core_src_b       <= sel_b;
          cnt              <= CNT_W'(CORE_LAT);
        end
      end
      if (state == EXEC) begin
        if (cnt != '0) begin
          cnt <= cnt - CNT_W'(1);
        end
        if (cnt <= CNT_W'(1)) begin
          rsp_data <= core_result;
          rsp_err  <= 1'b0;
        end
      end
    end
  end

`ifdef SIMD_ARB_STATS_EN
  // Per-requester transfer counters that stick at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_cnt <= '0;
    end else if (transfer) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && (grant_cnt[i*16 +: 16] != 16'hFFFF)) begin
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_simd_issue_arbiter.sv
// tb/tb_simd_issue_arbiter.sv - directed table-driven bench for simd_issue_arbiter
module tb_simd_issue_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int LANE_W   = 32;
  localparam int LANES    = 4;
  localparam int CORE_LAT = 1;
  localparam int VEC_W    = LANES * LANE_W;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*16-1:0]      req_instr;
  logic [NUM_REQ*VEC_W-1:0]   req_a;
  logic [NUM_REQ*VEC_W-1:0]   req_b;
  logic [15:0]                core_instruction;
  logic [VEC_W-1:0]           core_src_a;
  logic [VEC_W-1:0]           core_src_b;
  logic [VEC_W-1:0]           core_result;
  logic [NUM_REQ-1:0]         rsp_valid;
  logic                       rsp_ready;
  logic [VEC_W-1:0]           rsp_data;
  logic                       rsp_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          idx;
    logic [15:0] instr;
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] data;
    logic        err;
    int          lat;
    logic [15:0] ci;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  simd_issue_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .LANE_W   (LANE_W),
    .LANES    (LANES),
    .CORE_LAT (CORE_LAT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_instr        (req_instr),
    .req_a            (req_a),
    .req_b            (req_b),
    .core_instruction (core_instruction),
    .core_src_a       (core_src_a),
    .core_src_b       (core_src_b),
    .core_result      (core_result),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_data         (rsp_data),
    .rsp_err          (rsp_err)
  );

  // Reference SIMD core: lane-wise add or multiply, truncated to the lane width.
  always_comb begin
    core_result = '0;
    for (int l = 0; l < LANES; l++) begin
      case (core_instruction[15:14])
        2'b00:   core_result[l*LANE_W +: LANE_W] = core_src_a[l*LANE_W +: LANE_W] + core_src_b[l*LANE_W +: LANE_W];
        2'b01:   core_result[l*LANE_W +: LANE_W] = core_src_a[l*LANE_W +: LANE_W] * core_src_b[l*LANE_W +: LANE_W];
        default: core_result[l*LANE_W +: LANE_W] = '0;
      endcase
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input int idx, input logic [15:0] instr, input logic [127:0] a, input logic [127:0] b);
    req_valid[idx]            = 1'b1;
    req_instr[idx*16 +: 16]   = instr;
    req_a[idx*VEC_W +: VEC_W] = a;
    req_b[idx*VEC_W +: VEC_W] = b;
  endtask

  // Called on the first falling edge after an accept; returns cycles until rsp_valid.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (rsp_valid == '0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  function automatic logic [127:0] v4(input logic [31:0] x3, input logic [31:0] x2, input logic [31:0] x1, input logic [31:0] x0);
    return {x3, x2, x1, x0};
  endfunction

  function automatic logic [127:0] oh(input int n);
    return 128'(1) << n;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int ng;
    int nr;
    int cyc;
    logic overlap;
    int exp_order [5];
    logic stale;

    exp_order = '{0, 1, 2, 3, 0};

    vecs[0] = '{0, 16'h0012, v4(4, 3, 2, 1), v4(40, 30, 20, 10), v4(44, 33, 22, 11), 1'b0, 2, 16'h0012};
    vecs[1] = '{1, 16'h4034, v4(4, 3, 2, 1), v4(5, 6, 7, 8), v4(20, 18, 14, 8), 1'b0, 2, 16'h4034};
    vecs[2] = '{2, 16'hC0DE, v4(9, 9, 9, 9), v4(9, 9, 9, 9), 128'd0, 1'b1, 1, 16'h4034};
    vecs[3] = '{3, 16'h8001, v4(7, 7, 7, 7), v4(1, 1, 1, 1), 128'd0, 1'b1, 1, 16'h4034};
    vecs[4] = '{3, 16'h0005, v4(32'hFFFFFFFF, 32'h7FFFFFFF, 0, 32'h100), v4(1, 1, 0, 32'h23),
                v4(0, 32'h80000000, 0, 32'h123), 1'b0, 2, 16'h0005};
    vecs[5] = '{0, 16'h7FFF, v4(32'h10000, 32'h80000001, 0, 32'hFFFFFFFF), v4(32'h10000, 3, 5, 32'hFFFFFFFF),
                v4(0, 32'h80000003, 0, 1), 1'b0, 2, 16'h7FFF};

    reset     = 1'b0;
    req_valid = '0;
    req_instr = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    // Reset state, with a request pending to show nothing is offered.
    repeat (2) @(negedge clk);
    req_valid = 4'b0001;
    #1;
    check("rst_req_ready", 128'(req_ready), 128'd0);
    check("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    check("rst_rsp_data", rsp_data, 128'd0);
    check("rst_rsp_err", 128'(rsp_err), 128'd0);
    check("rst_core_instr", 128'(core_instruction), 128'd0);
    check("rst_core_a", core_src_a, 128'd0);
    check("rst_core_b", core_src_b, 128'd0);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Round robin: all four requesters continuously valid, consumer always ready.
    for (int i = 0; i < NUM_REQ; i++) begin
      drive_req(i, 16'h4000 + 16'(i), v4(4, 3, 2, 1), v4(5, 6, 7, 8));
    end
    rsp_ready = 1'b1;
    ng = 0;
    nr = 0;
    cyc = 0;
    overlap = 1'b0;
    while ((ng < 5 || nr < 5) && cyc < 60) begin
      #1;
      if (req_ready != '0 && rsp_valid != '0) overlap = 1'b1;
      if (req_ready != '0) begin
        if (ng < 5) check($sformatf("rr_grant%0d", ng), 128'(req_ready), oh(exp_order[ng]));
        ng++;
      end
      if (rsp_valid != '0) begin
        if (nr < 5) begin
          check($sformatf("rr_owner%0d", nr), 128'(rsp_valid), oh(exp_order[nr]));
          check($sformatf("rr_data%0d", nr), rsp_data, v4(20, 18, 14, 8));
        end
        nr++;
        if (nr == 5) req_valid = '0;
      end
      @(negedge clk);
      cyc++;
    end
    check("rr_grant_count", 128'(ng), 128'd5);
    check("rr_rsp_count", 128'(nr), 128'd5);
    check("rr_no_overlap", 128'(overlap), 128'd0);
    rsp_ready = 1'b0;
    req_valid = '0;
    @(negedge clk);

    // Single-request vectors, including reserved opcodes and lane wraparound.
    for (int v = 0; v < 6; v++) begin
      drive_req(vecs[v].idx, vecs[v].instr, vecs[v].a, vecs[v].b);
      #1;
      check($sformatf("v%0d_req_ready", v), 128'(req_ready), oh(vecs[v].idx));
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      wait_rsp(lat);
      check($sformatf("v%0d_latency", v), 128'(lat), 128'(vecs[v].lat));
      check($sformatf("v%0d_owner", v), 128'(rsp_valid), oh(vecs[v].idx));
      check($sformatf("v%0d_data", v), rsp_data, vecs[v].data);
      check($sformatf("v%0d_err", v), 128'(rsp_err), 128'(vecs[v].err));
      check($sformatf("v%0d_core_instr", v), 128'(core_instruction), 128'(vecs[v].ci));
      if (!vecs[v].err) check($sformatf("v%0d_core_a", v), core_src_a, vecs[v].a);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check($sformatf("v%0d_rsp_drop", v), 128'(rsp_valid), 128'd0);
    end

    // Backpressure: response held for five cycles while others wait.
    drive_req(1, 16'h0100, v4(4, 3, 2, 1), v4(40, 30, 20, 10));
    #1;
    check("bp_grant1", 128'(req_ready), oh(1));
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    drive_req(2, 16'h0200, v4(1, 1, 1, 1), v4(2, 2, 2, 2));
    drive_req(3, 16'h0300, v4(5, 5, 5, 5), v4(5, 5, 5, 5));
    wait_rsp(lat);
    check("bp_latency", 128'(lat), 128'd2);
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("bp_hold_valid%0d", c), 128'(rsp_valid), oh(1));
      check($sformatf("bp_hold_data%0d", c), rsp_data, v4(44, 33, 22, 11));
      check($sformatf("bp_hold_ready%0d", c), 128'(req_ready), 128'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_no_accept_on_handshake", 128'(req_ready), 128'd0);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check("bp_next_grant", 128'(req_ready), oh(2));
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(lat);
    check("bp2_owner", 128'(rsp_valid), oh(2));
    check("bp2_data", rsp_data, v4(3, 3, 3, 3));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    stale = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid != '0 || req_ready != '0) stale = 1'b1;
    end
    check("bp_single_accept", 128'(stale), 128'd0);

    // Reset in the middle of EXEC: everything clears and requester 0 wins first afterwards.
    drive_req(1, 16'h4001, v4(4, 3, 2, 1), v4(5, 6, 7, 8));
    #1;
    check("rx_grant1", 128'(req_ready), oh(1));
    @(posedge clk);
    @(negedge clk);
    req_valid = 4'b0100;
    reset = 1'b0;
    #1;
    check("rx_core_instr", 128'(core_instruction), 128'd0);
    check("rx_core_a", core_src_a, 128'd0);
    check("rx_rsp_valid", 128'(rsp_valid), 128'd0);
    check("rx_req_ready", 128'(req_ready), 128'd0);
    check("rx_rsp_data", rsp_data, 128'd0);
    @(negedge clk);
    req_valid = '0;
    reset = 1'b1;
    stale = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid != '0) stale = 1'b1;
    end
    check("rx_no_stale_rsp", 128'(stale), 128'd0);
    drive_req(0, 16'h0012, v4(4, 3, 2, 1), v4(40, 30, 20, 10));
    drive_req(3, 16'h0012, v4(1, 1, 1, 1), v4(1, 1, 1, 1));
    #1;
    check("rx_first_grant", 128'(req_ready), oh(0));
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(lat);
    check("rx_latency", 128'(lat), 128'd2);
    check("rx_owner", 128'(rsp_valid), oh(0));
    check("rx_data", rsp_data, v4(44, 33, 22, 11));
    check("rx_err", 128'(rsp_err), 128'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
